// File: rtl/button_pkg.sv
// Shared types and timing helpers for the push-button conditioner.
// Used by button_debounce; optional feature macro: BUTTON_LONG_PRESS_EN.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } db_state_t;

  localparam int unsigned DEF_CLK_HZ      = 16000000;
  localparam int unsigned DEF_DEBOUNCE_MS = 10;
  localparam int unsigned DEF_LONG_MS     = 1000;

  function automatic int unsigned ms_to_cycles(
    input int unsigned clk_hz,
    input int unsigned ms
  );
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Reset value is a parameter so the idle pad level survives reset.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the pad through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: sync, debounce, level/press/release pulses.
// Define BUTTON_LONG_PRESS_EN to add the long-press pulse on btn_long.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned CLK_HZ      = DEF_CLK_HZ,
  parameter int unsigned DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int unsigned LONG_MS     = DEF_LONG_MS,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WF_BUTTON,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_count
);

  localparam int unsigned DB_CYCLES =
    ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  db_state_t       state;
  logic [DB_W-1:0] db_cnt;
  logic            p;
  logic            s;
  logic            press_done;
  logic            release_done;

  assign p = WF_BUTTON ^ ACTIVE_LOW;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (p),
    .q  (s)
  );

  // Debounce window completes on this edge in either direction.
  always_comb begin
    press_done   = 1'b0;
    release_done = 1'b0;
    if (state == PRESS_DB && s && db_cnt == DB_LAST)
      press_done = 1'b1;
    if (state == RELEASE_DB && !s && db_cnt == DB_LAST)
      release_done = 1'b1;
  end

  // Debounce FSM with registered level, pulses and press counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      press_count <= 8'd0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            state  <= PRESS_DB;
            db_cnt <= DB_ONE;
          end
        end
        PRESS_DB: begin
          if (!s) begin
            state  <= IDLE;
            db_cnt <= '0;
          end else if (press_done) begin
            state       <= HELD;
            db_cnt      <= '0;
            btn_level   <= 1'b1;
            btn_press   <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
        HELD: begin
          if (!s) begin
            state  <= RELEASE_DB;
            db_cnt <= DB_ONE;
          end
        end
        RELEASE_DB: begin
          if (s) begin
            state  <= HELD;
            db_cnt <= '0;
          end else if (release_done) begin
            state       <= IDLE;
            db_cnt      <= '0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_ONE;
          end
        end
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LONG_CYCLES =
    ms_to_cycles(CLK_HZ, LONG_MS);
  localparam int HC_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(LONG_CYCLES);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(LONG_CYCLES - 1);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);

  logic [HC_W-1:0] hold_cnt;

  // Hold timer: restarts on a new press, saturates after one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (press_done) begin
        hold_cnt <= '0;
      end else if ((state == HELD || state == RELEASE_DB) &&
                   hold_cnt != HC_MAX) begin
        hold_cnt <= hold_cnt + HC_ONE;
        btn_long <= (hold_cnt == HC_LAST);
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized + directed bench for button_debounce with a pad-history model.
// Optional feature macro: BUTTON_LONG_PRESS_EN.
module tb_button_debounce;

  localparam int DB = 4;
  localparam int LG = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pad = 1'b1;
  logic       lvl;
  logic       prs;
  logic       rls;
  logic       lng;
  logic [7:0] cnt;

  int tests = 0;
  int fails = 0;
  int npress = 0;
  int nrel = 0;
  int nlong = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .WF_BUTTON  (pad),
    .btn_level  (lvl),
    .btn_press  (prs),
    .btn_release(rls),
    .btn_long   (lng),
    .press_count(cnt)
  );

  // Model: pressed-level history since reset; an event fires when the
  // synchronized level has disagreed with the debounced level for DB edges.
  int ph[$];
  int sh[$];
  bit m_lvl = 0;
  bit m_prs = 0;
  bit m_rls = 0;
  bit m_lng = 0;
  int m_cnt = 0;
  int nedge = 0;
  int pedge = -1000;

  initial begin
    ph = {0, 0};
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        ph = {0, 0};
        sh = {};
        m_lvl = 0; m_prs = 0; m_rls = 0; m_lng = 0;
        m_cnt = 0; nedge = 0; pedge = -1000;
      end else begin
        bit lb;
        bit flip;
        int sv;
        lb = m_lvl;
        nedge++;
        ph.push_back(pad ? 0 : 1);
        sv = ph[ph.size() - 3];
        if (ph.size() > 3) void'(ph.pop_front());
        sh.push_back(sv);
        if (sh.size() > DB) void'(sh.pop_front());
        flip = (sh.size() == DB);
        foreach (sh[k]) if (sh[k] == int'(lb)) flip = 0;
        m_prs = flip && !lb;
        m_rls = flip && lb;
`ifdef BUTTON_LONG_PRESS_EN
        m_lng = lb && (nedge - pedge == LG);
`else
        m_lng = 0;
`endif
        if (flip) m_lvl = !lb;
        if (m_prs) begin
          m_cnt = (m_cnt + 1) % 256;
          pedge = nedge;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus event tallies.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (lvl !== m_lvl || prs !== m_prs || rls !== m_rls ||
          lng !== m_lng || cnt !== 8'(m_cnt)) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got lvl=%b prs=%b rls=%b lng=%b cnt=%0d exp lvl=%b prs=%b rls=%b lng=%b cnt=%0d",
                 $time, lvl, prs, rls, lng, cnt,
                 m_lvl, m_prs, m_rls, m_lng, m_cnt);
      end
      if (prs === 1'b1) npress++;
      if (rls === 1'b1) nrel++;
      if (lng === 1'b1) nlong++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edges from the current drive point until the chosen event, -1 on timeout.
  task automatic wait_evt(input int which, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      @(negedge clk);
      if ((which == 0 && prs) || (which == 1 && rls) ||
          (which == 2 && lng)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int p0;
    int r0;
    int l0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", int'(lvl), 0);
    chk("rst_press", int'(prs), 0);
    chk("rst_release", int'(rls), 0);
    chk("rst_long", int'(lng), 0);
    chk("rst_count", int'(cnt), 0);
    rst = 1'b0;
    repeat (5) step();

    // Glitch shorter than the window
    p0 = npress;
    pad = 1'b0;
    repeat (3) step();
    pad = 1'b1;
    repeat (20) step();
    chk("glitch_press", npress - p0, 0);
    chk("glitch_level", int'(lvl), 0);
    chk("glitch_count", int'(cnt), 0);

    // Clean press and release
    pad = 1'b0;
    wait_evt(0, 30, n);
    chk("clean_latency", n, 6);
    #1;
    chk("clean_level", int'(lvl), 1);
    chk("clean_count", int'(cnt), 1);
    chk("model_level", int'(m_lvl), 1);
    step();
    pad = 1'b1;
    wait_evt(1, 30, n);
    chk("release_latency", n, 6);

    // Bounce then settle pressed
    repeat (5) step();
    p0 = npress;
    r0 = nrel;
    pad = 1'b0; step();
    pad = 1'b1; step();
    pad = 1'b0; step();
    pad = 1'b1; step();
    pad = 1'b0;
    wait_evt(0, 30, n);
    chk("bounce_latency", n, 6);
    repeat (10) step();
    chk("bounce_presses", npress - p0, 1);
    chk("bounce_releases", nrel - r0, 0);
    pad = 1'b1;
    wait_evt(1, 30, n);

    // Long hold of 40 cycles after the press
    repeat (5) step();
    l0 = nlong;
    pad = 1'b0;
    wait_evt(0, 30, n);
`ifdef BUTTON_LONG_PRESS_EN
    wait_evt(2, 40, n);
    chk("long_latency", n, LG);
    repeat (40 - LG) step();
    chk("long_pulses", nlong - l0, 1);
`else
    repeat (40) step();
    chk("long_pulses", nlong - l0, 0);
`endif
    pad = 1'b1;
    wait_evt(1, 30, n);
    chk("pre_wrap_count", int'(cnt), 3);

    // 256 press/release cycles wrap the counter back
    p0 = npress;
    r0 = nrel;
    for (int i = 0; i < 256; i++) begin
      pad = 1'b0;
      repeat (8) step();
      pad = 1'b1;
      repeat (8) step();
    end
    chk("wrap_count", int'(cnt), 3);
    chk("wrap_presses", npress - p0, 256);
    chk("wrap_releases", nrel - r0, 256);

    // Reset two cycles into a hold, button kept down
    pad = 1'b0;
    wait_evt(0, 30, n);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_level", int'(lvl), 0);
    chk("midrst_count", int'(cnt), 0);
    repeat (2) step();
    rst = 1'b0;
    wait_evt(0, 30, n);
    chk("postrst_latency", n, 6);
    #1;
    chk("postrst_count", int'(cnt), 1);
    step();
    pad = 1'b1;
    wait_evt(1, 30, n);

    // Random pad runs with occasional resets
    for (int i = 0; i < 3000;) begin
      int len;
      pad = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      repeat (len) step();
      i += len;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    pad = 1'b1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the LED drivers: conditions the WebFPGA on-board user push-button into clean, clock-synchronous level and event signals.
- Raw pad input → 2-flop synchronizer → debounce FSM → registered level, press/release pulses and a wrapping press counter.
- Sits at top level beside the LED logic, clocked by the same 16 MHz `clk`.

Parameters:
- `CLK_HZ`, 16000000: clock frequency in Hz.
- `DEBOUNCE_MS`, 10: required stable time in ms. `DB_CYCLES = (CLK_HZ/1000)*DEBOUNCE_MS`, must be ≥ 2.
- `LONG_MS`, 1000: hold time for a long-press event in ms. `LONG_CYCLES = (CLK_HZ/1000)*LONG_MS`. Used only with `BUTTON_LONG_PRESS_EN`.
- `ACTIVE_LOW`, 1: 1 = pad reads 0 when pressed; 0 = pad reads 1 when pressed.

Ports:
- `clk`  input  1  system clock, 16 MHz.
- `rst`  input  1  asynchronous, active-high reset.
- `WF_BUTTON`  input  1  raw, asynchronous button pad.
- `btn_level`  output  1  debounced pressed level; 1 = pressed.
- `btn_press`  output  1  one-cycle pulse on debounced press.
- `btn_release`  output  1  one-cycle pulse on debounced release.
- `btn_long`  output  1  one-cycle pulse when a hold reaches LONG_CYCLES (0 when the feature is disabled).
- `press_count`  output  8  number of debounced presses, wraps modulo 256.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset:
  - Synchronizer flops reset to the released pad level.
  - FSM resets to IDLE; all counters 0.
  - `btn_level`=0, `btn_press`=0, `btn_release`=0, `btn_long`=0, `press_count`=0.
- Synchronizer:
  - `p` = `WF_BUTTON` XOR `ACTIVE_LOW`, so `p`=1 means pressed.
  - Two flops produce `s`; `s` lags the pad by 2 edges.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. `db_cnt` is `$clog2(DB_CYCLES+1)` bits.
  - IDLE: `s`=1 → go to PRESS_DB with `db_cnt`=1.
  - PRESS_DB:
    - `s`=0 → back to IDLE, `db_cnt`=0, no event.
    - `s`=1 and `db_cnt`=DB_CYCLES-1 → go to HELD.
    - Otherwise `db_cnt`++.
  - HELD: `s`=0 → go to RELEASE_DB with `db_cnt`=1.
  - RELEASE_DB:
    - `s`=1 → back to HELD, `db_cnt`=0, no event.
    - `s`=0 and `db_cnt`=DB_CYCLES-1 → go to IDLE.
    - Otherwise `db_cnt`++.
- Net effect: an event needs `s` stable for exactly DB_CYCLES consecutive edges.
- Outputs are registered and change on the same edge as the FSM transition:
  - Entering HELD: `btn_level`←1, `btn_press`=1 for 1 cycle, `press_count`++.
  - Entering IDLE from RELEASE_DB: `btn_level`←0, `btn_release`=1 for 1 cycle.
- Latency: a clean pad edge at cycle 0 produces the pulse at edge 2+DB_CYCLES.
- `btn_level` holds its value through bounce. Glitches shorter than DB_CYCLES never produce events.
- `press_count` wraps 255→0 with no flag.
- `btn_press` and `btn_release` are never high in the same cycle. Minimum spacing between them is DB_CYCLES.
- Button held through reset release: after reset, `s`=1, so a press is reported 2+DB_CYCLES edges after `rst` falls.
- Reset asserted mid-debounce or mid-hold: immediate clear, no pulse emitted.

Optional Feature:
- Macro: `BUTTON_LONG_PRESS_EN`.
- Defined:
  - `hold_cnt` (`$clog2(LONG_CYCLES+1)` bits) clears on entry to HELD and increments while in HELD and RELEASE_DB.
  - When it reaches LONG_CYCLES, `btn_long` pulses 1 cycle. It fires at most once per hold, then saturates.
  - Release bounce (RELEASE_DB→HELD) does not restart `hold_cnt`.
  - Reset clears it.
- Undefined: `btn_long` tied 0; no hold counter is synthesized.

Decomposition:
- Shared package/header `button_pkg`:
  - FSM state encodings (IDLE=0, PRESS_DB=1, HELD=2, RELEASE_DB=3).
  - Constant function `ms_to_cycles(clk_hz, ms)`.
  - Default timing constants.
- One sub-module: `sync_2ff` (parameterised reset value, async active-high reset). Reused for any future pad inputs.

Test Plan:
All tests use `CLK_HZ`=1000, `DEBOUNCE_MS`=4 (DB_CYCLES=4), `LONG_MS`=20 (LONG_CYCLES=20), `ACTIVE_LOW`=1.
1. Clean press: `WF_BUTTON` 1→0 at cycle 10 and held → `btn_press` high exactly at edge 16 for 1 cycle; `btn_level`=1 from then; `press_count`=1.
2. Bounce: pad toggles 0,1,0,1 every cycle, then settles at 0 → exactly one `btn_press`, 4+2 edges after the final settle; no `btn_release`.
3. Glitch: a 3-cycle low pulse from idle → no events, `btn_level` stays 0, `press_count`=0.
4. Wrap: 256 clean press/release cycles → `press_count` returns to 0; 256 press and 256 release pulses.
5. Long press (feature on): hold 40 cycles → one `btn_long` pulse 20 cycles after `btn_press`; none after it. Feature off → `btn_long` stays 0.
6. Reset: assert `rst` 2 cycles after `btn_press` while held, then release → outputs immediately 0; `btn_press` again 6 edges after `rst` falls; `press_count`=1.
